// File: rtl/player_input_ctrl_if.sv
// Key/strobe bundle between the raw push-buttons and player_register.
// slave = player_input_ctrl side, master = board/testbench side.
interface player_input_ctrl_if;
   logic key_forward_n;
   logic key_rotate_n;
   logic forward;
   logic rotate;
   logic fwd_held;
   logic rot_held;

   modport slave (
      input  key_forward_n,
      input  key_rotate_n,
      output forward,
      output rotate,
      output fwd_held,
      output rot_held
   );

   modport master (
      output key_forward_n,
      output key_rotate_n,
      input  forward,
      input  rotate,
      input  fwd_held,
      input  rot_held
   );
endinterface

// File: rtl/player_input_ctrl.sv
// Sync + debounce + press-edge strobes for forward/rotate keys, forward wins arbitration.
// Define PLAYER_INPUT_AUTOREPEAT_EN to add per-key hold-to-repeat strobes.
module player_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
   , parameter int REPEAT_DELAY  = 25000000
   , parameter int REPEAT_PERIOD = 2500000
`endif
) (
   input  logic                 clk,
   input  logic                 resetn,
   player_input_ctrl_if.slave   io
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;
`endif

   // Index 0 = forward, index 1 = rotate.
   logic [1:0] key_n;
   logic [1:0] held;
   logic [1:0] req;

   assign key_n = {io.key_rotate_n, io.key_forward_n};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_key
         logic             sync1_q, sync1_d;
         logic             sync2_q, sync2_d;
         logic             deb_q, deb_d;
         logic             prev_q, prev_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             press;

         always_comb begin
            sync1_d = key_n[gi];
            sync2_d = sync1_q;
            prev_d  = deb_q;
            deb_d   = deb_q;
            cnt_d   = '0;
            if (~sync2_q != deb_q) begin
               if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1))
                  deb_d = ~sync2_q;
               else
                  cnt_d = cnt_q + CNT_W'(1);
            end
         end

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               sync1_q <= 1'b1;
               sync2_q <= 1'b1;
               deb_q   <= 1'b0;
               prev_q  <= 1'b0;
               cnt_q   <= '0;
            end else begin
               sync1_q <= sync1_d;
               sync2_q <= sync2_d;
               deb_q   <= deb_d;
               prev_q  <= prev_d;
               cnt_q   <= cnt_d;
            end
         end

         assign press    = deb_q & ~prev_q;
         assign held[gi] = deb_q;

`ifdef PLAYER_INPUT_AUTOREPEAT_EN
         rpt_state_e       st_q, st_d;
         logic [RPT_W-1:0] rcnt_q, rcnt_d;
         logic             rreq;

         // Release (deb_q low) always wins over a due repeat strobe.
         always_comb begin
            st_d   = st_q;
            rcnt_d = rcnt_q;
            rreq   = 1'b0;
            case (st_q)
               IDLE: begin
                  if (press) begin
                     st_d   = DELAY;
                     rcnt_d = '0;
                     rreq   = 1'b1;
                  end
               end
               DELAY: begin
                  if (!deb_q) begin
                     st_d   = IDLE;
                     rcnt_d = '0;
                  end else if (rcnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                     st_d   = REPEAT;
                     rcnt_d = '0;
                     rreq   = 1'b1;
                  end else begin
                     rcnt_d = rcnt_q + RPT_W'(1);
                  end
               end
               REPEAT: begin
                  if (!deb_q) begin
                     st_d   = IDLE;
                     rcnt_d = '0;
                  end else if (rcnt_q == RPT_W'(REPEAT_PERIOD - 1)) begin
                     rcnt_d = '0;
                     rreq   = 1'b1;
                  end else begin
                     rcnt_d = rcnt_q + RPT_W'(1);
                  end
               end
               default: begin
                  st_d   = IDLE;
                  rcnt_d = '0;
               end
            endcase
         end

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               st_q   <= IDLE;
               rcnt_q <= '0;
            end else begin
               st_q   <= st_d;
               rcnt_q <= rcnt_d;
            end
         end

         assign req[gi] = rreq;
`else
         assign req[gi] = press;
`endif
      end
   endgenerate

   logic forward_q, forward_d;
   logic rotate_q, rotate_d;
   logic rotate_pending_q, rotate_pending_d;

   // A colliding rotate is parked for one strobe; extra requests merge into it.
   always_comb begin
      forward_d        = req[0];
      rotate_d         = 1'b0;
      rotate_pending_d = 1'b0;
      if (req[0])
         rotate_pending_d = rotate_pending_q | req[1];
      else
         rotate_d = rotate_pending_q | req[1];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         forward_q        <= 1'b0;
         rotate_q         <= 1'b0;
         rotate_pending_q <= 1'b0;
      end else begin
         forward_q        <= forward_d;
         rotate_q         <= rotate_d;
         rotate_pending_q <= rotate_pending_d;
      end
   end

   assign io.forward  = forward_q;
   assign io.rotate   = rotate_q;
   assign io.fwd_held = held[0];
   assign io.rot_held = held[1];

endmodule
